sd_arbiter: RTL and testbench
=============================

# sd_arbiter

Sector-transfer controller that shares the single SD-card emulation channel of the MiST IO link between two core-side requesters, for example the floppy and hard-disk controllers. It arbitrates requests round-robin and drives `sd_lba`/`sd_rd`/`sd_wr` toward the IO-link block. It synchronises that block's SPI-clocked `sd_ack`/strobe handshake into `clk_sys`. It moves 512-byte sectors through an internal buffer that the requesters read and write while the block is idle.

## Interface
- `ACK_TIMEOUT`, default 50_000_000 — `clk_sys` cycles to wait for `sd_ack` before aborting a request.
- `clk_sys` in 1 — single system clock; must run at ≥4× SPI_SCK.
- `reset` in 1 — asynchronous, active-high.
- `req0_lba` / `req1_lba` in 32 — sector address of each requester.
- `req0_rd`, `req0_wr` / `req1_rd`, `req1_wr` in 1 — level request; held until done or error.
- `req0_done`, `req0_err` / `req1_done`, `req1_err` out 1 — one-cycle completion or failure pulse.
- `busy` out 1 — high whenever the state is not IDLE.
- `buf_addr` in 9, `buf_din` in 8, `buf_we` in 1, `buf_dout` out 8 — requester port to the sector buffer.
- `sd_lba` out 32, `sd_rd` out 1, `sd_wr` out 1 — to the IO-link block.
- `sd_ack` in 1, `sd_dout` in 8, `sd_dout_strobe` in 1, `sd_din_strobe` in 1 — from the IO-link block; asynchronous (SPI_SCK domain).
- `sd_din` out 8 — byte for an FPGA→IO sector write.

## Operation
- Input sync: `sd_ack`, `sd_dout_strobe` and `sd_din_strobe` each pass through 2 flops, plus a third flop for edge detection.
  - `ack_rise`, `ack_fall`, `dout_rise`, `din_rise` are one-cycle pulses.
  - `sd_dout` is captured on `dout_rise`. It is stable there because a byte spans 8 SCK periods.
- States: IDLE, REQ, XFER, FIN.
- IDLE:
  - Pending means `rd|wr` is high. If one requester has both, `rd` wins.
  - Round-robin: the requester not served last wins a tie. After reset, req0 has priority.
  - On grant: latch the owner, direction and `lba`; drive `sd_lba`; assert `sd_rd` or `sd_wr`; clear `cnt` (10 bit); go to REQ.
- REQ:
  - `ack_rise`: deassert `sd_rd`/`sd_wr`, go to XFER.
  - Timeout counter reaching `ACK_TIMEOUT`: deassert `sd_rd`/`sd_wr`, pulse `err` to the owner, go to IDLE.
- XFER, read direction:
  - On each `dout_rise` with `cnt` < 512: write `sd_dout` to `buf[cnt]` and increment `cnt`.
  - Strobes at `cnt` = 512 are dropped and set an overflow flag.
- XFER, write direction:
  - `sd_din` = `buf[ptr]`.
  - The first `din_rise` after `ack_rise` does not advance `ptr`. Each later `din_rise` increments `ptr` and `cnt`.
- XFER exit: `ack_fall` goes to FIN.
- FIN: pulse `done` to the owner if `cnt` = 512 and no overflow; otherwise pulse `err`. Go to IDLE.
- A requester must drop `rd`/`wr` in the cycle after its `done`/`err` pulse. IDLE spends at least one cycle before the next grant.
- Buffer port:
  - `buf_we` is honoured only in IDLE and ignored otherwise.
  - `buf_dout` is always `buf[buf_addr]` with one-cycle latency.
- `sd_dout_strobe` while not in XFER (config data) is ignored.
- `ack_rise` outside REQ is ignored.

## Timing
- Reset values: `sd_lba` = 0, `sd_rd` = `sd_wr` = 0, `sd_din` = 0, all `done`/`err` = 0, `busy` = 0, `buf_dout` = 0. State is IDLE, round-robin pointer is req0, synchroniser flops are 0.
- Reset mid-transfer aborts silently with no pulses.
  - A stale `sd_ack` high after reset is seen as a rise while in IDLE and ignored.
  - A later `ack_fall` is also ignored.
- Grant latency: `sd_rd`/`sd_wr` rise 1 cycle after a request is first sampled in IDLE.
- Event latency: 3 `clk_sys` cycles from a SPI-domain edge to the internal pulse.
- Buffer latency:
  - `sd_din` updates 1 cycle after `ptr` changes (synchronous RAM read).
  - This must complete within one SPI byte time.
- `cnt` wraps never; it saturates at 512.
- `ptr` is 9 bit and wraps 511→0, which is harmless because the transfer ends.
- If `buf_we` and an XFER buffer write coincide: no conflict, since `buf_we` is ignored outside IDLE.

## Structure
- Package `sd_arb_pkg`: state enum, `SECTOR_BYTES` = 512, `SECT_AW` = 9, `CNT_W` = 10.
- Sub-module `sd_sector_buf`: 512×8 true dual-port RAM with synchronous read.
  - Port A: requester.
  - Port B: transfer engine.
- Synchronisers are inline, not a sub-module.

## Test plan
- Single read: req0_rd with `lba` 0x1234. Expect `sd_rd` high and `sd_lba` = 0x1234. Ack, then 512 strobes with bytes `i&0xFF`, then ack low. Expect one `req0_done`; `buf` read-back shows `buf[i]` = `i&0xFF`.
- Single write: preload `buf[i]` = `~i` and raise req1_wr. Expect `sd_din` to present 0xFF, 0xFE, … across 513 `din_strobe` edges, then `req1_done`.
- Contention:
  - req0_rd and req1_rd asserted together. Expect req0 served first, then req1.
  - Repeat with both asserted again. Expect req1 served first.
- Short transfer: ack falls after 100 strobes. Expect `err` pulse and no `done`.
- Timeout with `ACK_TIMEOUT` = 1000 and no ack. Expect `sd_rd` to drop and `err` at cycle 1001.
- Reset asserted mid-XFER with `sd_ack` held high, then released. Expect all outputs 0 and no pulses; the next request completes normally.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types and sizes for the SD sector-transfer arbiter.
package sd_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_FIN} state_t;
  localparam int SECTOR_BYTES = 512;
  localparam int SECT_AW      = 9;
  localparam int CNT_W        = 10;
endpackage

// File: rtl/sd_sector_buf.sv
// 512x8 true dual-port sector RAM with synchronous read on both ports.
// Port A faces the requesters, port B the transfer engine.
module sd_sector_buf
  import sd_arb_pkg::*;
(
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [SECT_AW-1:0] addr_a,
  input  logic [7:0]         din_a,
  input  logic               we_a,
  output logic [7:0]         dout_a,
  input  logic [SECT_AW-1:0] addr_b,
  input  logic [7:0]         din_b,
  input  logic               we_b,
  output logic [7:0]         dout_b
);
  logic [7:0] mem [SECTOR_BYTES];

  always_ff @(posedge clk_sys) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      dout_a <= mem[addr_a];
      dout_b <= mem[addr_b];
    end
  end
endmodule

// File: rtl/sd_arbiter.sv
// Round-robin arbiter sharing the MiST SD emulation channel between two requesters.
// state | meaning
// IDLE  | buffer belongs to requesters; grant the next pending request
// REQ   | sd_rd/sd_wr raised, waiting for sd_ack or timeout
// XFER  | bytes move between the IO link and the sector buffer
// FIN   | report done/err to the owner
module sd_arbiter
  import sd_arb_pkg::*;
#(
  parameter int ACK_TIMEOUT = 50_000_000
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [31:0]        req0_lba,
  input  logic               req0_rd,
  input  logic               req0_wr,
  output logic               req0_done,
  output logic               req0_err,
  input  logic [31:0]        req1_lba,
  input  logic               req1_rd,
  input  logic               req1_wr,
  output logic               req1_done,
  output logic               req1_err,
  output logic               busy,
  input  logic [SECT_AW-1:0] buf_addr,
  input  logic [7:0]         buf_din,
  input  logic               buf_we,
  output logic [7:0]         buf_dout,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic [7:0]         sd_dout,
  input  logic               sd_dout_strobe,
  input  logic               sd_din_strobe,
  output logic [7:0]         sd_din
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SECTOR_BYTES);

  state_t             state;
  logic [2:0]         ack_s, dout_s, din_s;
  logic               ack_rise, ack_fall, dout_rise, din_rise;
  logic               owner, last_served, dir_wr, hold, first_din, ovf;
  logic [CNT_W-1:0]   cnt;
  logic [SECT_AW-1:0] ptr;
  logic [31:0]        tmr;
  logic               pend0, pend1, pick1, gnt_rd, gnt_wr;
  logic               we_b;
  logic [SECT_AW-1:0] addr_b;

  // Two flops against metastability, the third only for edge detection.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ack_s  <= '0;
      dout_s <= '0;
      din_s  <= '0;
    end else begin
      ack_s  <= {ack_s[1:0], sd_ack};
      dout_s <= {dout_s[1:0], sd_dout_strobe};
      din_s  <= {din_s[1:0], sd_din_strobe};
    end
  end

  assign ack_rise  = ack_s[1] & ~ack_s[2];
  assign ack_fall  = ~ack_s[1] & ack_s[2];
  assign dout_rise = dout_s[1] & ~dout_s[2];
  assign din_rise  = din_s[1] & ~din_s[2];

  assign pend0  = req0_rd | req0_wr;
  assign pend1  = req1_rd | req1_wr;
  assign pick1  = pend1 & (~pend0 | ~last_served);
  assign gnt_rd = pick1 ? req1_rd : req0_rd;
  assign gnt_wr = ~gnt_rd & (pick1 ? req1_wr : req0_wr);
  assign busy   = (state != S_IDLE);

  assign we_b   = (state == S_XFER) & ~dir_wr & dout_rise & (cnt != CNT_FULL);
  assign addr_b = dir_wr ? ptr : cnt[SECT_AW-1:0];

  sd_sector_buf u_buf (
    .clk_sys (clk_sys),
    .reset   (reset),
    .addr_a  (buf_addr),
    .din_a   (buf_din),
    .we_a    (buf_we & ~busy),
    .dout_a  (buf_dout),
    .addr_b  (addr_b),
    .din_b   (sd_dout),
    .we_b    (we_b),
    .dout_b  (sd_din)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      dir_wr      <= 1'b0;
      hold        <= 1'b0;
      first_din   <= 1'b0;
      ovf         <= 1'b0;
      cnt         <= '0;
      ptr         <= '0;
      tmr         <= '0;
      sd_lba      <= '0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      req0_done   <= 1'b0;
      req0_err    <= 1'b0;
      req1_done   <= 1'b0;
      req1_err    <= 1'b0;
    end else begin
      req0_done <= 1'b0;
      req0_err  <= 1'b0;
      req1_done <= 1'b0;
      req1_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          // hold gives the previous owner a cycle to drop its request
          hold <= 1'b0;
          if (!hold && (pend0 || pend1)) begin
            owner       <= pick1;
            last_served <= pick1;
            dir_wr      <= gnt_wr;
            sd_lba      <= pick1 ? req1_lba : req0_lba;
            sd_rd       <= gnt_rd;
            sd_wr       <= gnt_wr;
            cnt         <= '0;
            ptr         <= '0;
            ovf         <= 1'b0;
            first_din   <= 1'b1;
            tmr         <= 32'(ACK_TIMEOUT);
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_rise) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= S_XFER;
          end else if (tmr == '0) begin
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            req0_err <= ~owner;
            req1_err <= owner;
            hold     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_XFER: begin
          if (!dir_wr && dout_rise) begin
            if (cnt == CNT_FULL) ovf <= 1'b1;
            else                 cnt <= cnt + 1'b1;
          end
          // The first din strobe fetches buf[0], already presented on sd_din.
          if (dir_wr && din_rise) begin
            if (first_din) begin
              first_din <= 1'b0;
            end else begin
              ptr <= ptr + 1'b1;
              if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
            end
          end
          if (ack_fall) state <= S_FIN;
        end
        S_FIN: begin
          if (cnt == CNT_FULL && !ovf) begin
            req0_done <= ~owner;
            req1_done <= owner;
          end else begin
            req0_err <= ~owner;
            req1_err <= owner;
          end
          hold  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_arbiter.sv
// Self-checking bench for sd_arbiter: reads, writes, arbitration, errors, reset.
module tb_sd_arbiter;
  logic        clk_sys;
  logic        reset;
  logic [31:0] req0_lba, req1_lba;
  logic        req0_rd, req0_wr, req1_rd, req1_wr;
  logic        req0_done, req0_err, req1_done, req1_err;
  logic        busy;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_din, buf_dout;
  logic        buf_we;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack, sd_dout_strobe, sd_din_strobe;
  logic [7:0]  sd_dout, sd_din;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int rr_last = 1;
  int n_done0 = 0, n_err0 = 0, n_done1 = 0, n_err1 = 0;

  sd_arbiter #(.ACK_TIMEOUT(1000)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req0_lba(req0_lba), .req0_rd(req0_rd), .req0_wr(req0_wr),
    .req0_done(req0_done), .req0_err(req0_err),
    .req1_lba(req1_lba), .req1_rd(req1_rd), .req1_wr(req1_wr),
    .req1_done(req1_done), .req1_err(req1_err),
    .busy(busy),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we), .buf_dout(buf_dout),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_dout(sd_dout), .sd_dout_strobe(sd_dout_strobe),
    .sd_din_strobe(sd_din_strobe), .sd_din(sd_din)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (req0_done) n_done0++;
    if (req0_err)  n_err0++;
    if (req1_done) n_done1++;
    if (req1_err)  n_err1++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_grant(output int lat);
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) begin lat = i; break; end
    end
  endtask

  task automatic wait_finish(output int who, output bit was_done);
    who = -1;
    was_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (req0_done || req0_err) begin
        who = 0; was_done = req0_done; req0_rd = 0; req0_wr = 0; break;
      end
      if (req1_done || req1_err) begin
        who = 1; was_done = req1_done; req1_rd = 0; req1_wr = 0; break;
      end
    end
  endtask

  task automatic spi_read(input int n, input int seed, input bit push);
    sd_ack = 1'b1;
    cyc(6);
    checks++;
    if (sd_rd !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ack_handshake: sd_rd=%b busy=%b want 0/1", sd_rd, busy);
    end
    for (int i = 0; i < n; i++) begin
      sd_dout = 8'(i + seed);
      sd_dout_strobe = 1'b1; cyc(3);
      sd_dout_strobe = 1'b0; cyc(3);
      if (push && i < 512) exp_q.push_back((i + seed) & 255);
    end
  endtask

  task automatic check_readback(input string name);
    int e;
    for (int i = 0; i < 512; i++) begin
      buf_addr = 9'(i);
      cyc(1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      checks++;
      if (buf_dout !== 8'(e)) begin
        errors++; $display("FAIL %s[%0d]: got %h want %h", name, i, buf_dout, 8'(e));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    checks++;
    if ({sd_rd, sd_wr, busy, req0_done, req0_err, req1_done, req1_err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl: rd=%b wr=%b busy=%b pulses=%b%b%b%b want 0",
        sd_rd, sd_wr, busy, req0_done, req0_err, req1_done, req1_err);
    end
    checks++;
    if (sd_lba !== 32'h0) begin errors++; $display("FAIL reset_lba: got %h want 0", sd_lba); end
    checks++;
    if (sd_din !== 8'h0 || buf_dout !== 8'h0) begin
      errors++; $display("FAIL reset_data: sd_din=%h buf_dout=%h want 0", sd_din, buf_dout);
    end
    reset = 1'b0;
    cyc(3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_read();
    int lat, who, d0;
    bit ok;
    d0 = n_done0;
    req0_lba = 32'h1234; req0_rd = 1'b1;
    wait_grant(lat);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL read_grant_latency: got %0d want 1", lat); end
    checks++;
    if (sd_rd !== 1'b1 || sd_wr !== 1'b0 || sd_lba !== 32'h1234) begin
      errors++; $display("FAIL read_grant: rd=%b wr=%b lba=%h want 1/0/1234", sd_rd, sd_wr, sd_lba);
    end
    rr_last = 0;
    spi_read(512, 0, 1'b1);
    // a requester write outside IDLE must not land in the buffer
    buf_addr = 9'd5; buf_din = 8'hA5; buf_we = 1'b1; cyc(1); buf_we = 1'b0;
    sd_ack = 1'b0;
    wait_finish(who, ok);
    checks++;
    if (who != 0 || ok !== 1'b1) begin
      errors++; $display("FAIL read_done: who=%0d done=%b want 0/1", who, ok);
    end
    cyc(3);
    checks++;
    if (n_done0 != d0 + 1) begin errors++; $display("FAIL read_done_count: got %0d want %0d", n_done0 - d0, 1); end
    check_readback("read_buf");
  endtask

  task automatic test_write();
    int lat, who, e;
    bit ok;
    for (int i = 0; i < 512; i++) begin
      buf_addr = 9'(i); buf_din = ~8'(i); buf_we = 1'b1; cyc(1);
    end
    buf_we = 1'b0;
    req1_lba = 32'hABCD0001; req1_wr = 1'b1;
    wait_grant(lat);
    checks++;
    if (lat != 1 || sd_wr !== 1'b1 || sd_rd !== 1'b0 || sd_lba !== 32'hABCD0001) begin
      errors++; $display("FAIL write_grant: lat=%0d rd=%b wr=%b lba=%h want 1/0/1/abcd0001", lat, sd_rd, sd_wr, sd_lba);
    end
    rr_last = 1;
    sd_ack = 1'b1;
    cyc(6);
    checks++;
    if (sd_din !== 8'hFF) begin errors++; $display("FAIL write_first_byte: got %h want ff", sd_din); end
    for (int k = 1; k <= 513; k++) begin
      exp_q.push_back((~(k - 1)) & 255);
      sd_din_strobe = 1'b1; cyc(3);
      sd_din_strobe = 1'b0; cyc(3);
      e = exp_q.pop_front();
      checks++;
      if (sd_din !== 8'(e)) begin
        errors++; $display("FAIL write_din[%0d]: got %h want %h", k, sd_din, 8'(e));
      end
    end
    sd_ack = 1'b0;
    wait_finish(who, ok);
    checks++;
    if (who != 1 || ok !== 1'b1) begin
      errors++; $display("FAIL write_done: who=%0d done=%b want 1/1", who, ok);
    end
  endtask

  task automatic test_contention(input string name);
    int first, lat, who;
    bit ok;
    first = (rr_last == 0) ? 1 : 0;
    exp_q.push_back(first);
    exp_q.push_back(1 - first);
    req0_lba = 32'h100; req1_lba = 32'h200;
    req0_rd = 1'b1; req1_rd = 1'b1;
    for (int t = 0; t < 2; t++) begin
      int e;
      wait_grant(lat);
      e = exp_q.pop_front();
      checks++;
      if (lat < 0 || sd_lba !== ((e == 1) ? 32'h200 : 32'h100)) begin
        errors++; $display("FAIL %s_grant%0d: lat=%0d lba=%h want req%0d", name, t, lat, sd_lba, e);
      end
      rr_last = e;
      spi_read(512, 3 * t + 1, 1'b0);
      sd_ack = 1'b0;
      wait_finish(who, ok);
      checks++;
      if (who != e || ok !== 1'b1) begin
        errors++; $display("FAIL %s_done%0d: who=%0d done=%b want %0d/1", name, t, who, ok, e);
      end
    end
  endtask

  task automatic test_short();
    int lat, who, d0, e0;
    bit ok;
    d0 = n_done0; e0 = n_err0;
    req0_lba = 32'h300; req0_rd = 1'b1;
    wait_grant(lat);
    rr_last = 0;
    spi_read(100, 0, 1'b0);
    sd_ack = 1'b0;
    wait_finish(who, ok);
    checks++;
    if (who != 0 || ok !== 1'b0) begin
      errors++; $display("FAIL short_err: who=%0d done=%b want 0/0", who, ok);
    end
    cyc(3);
    checks++;
    if (n_done0 != d0 || n_err0 != e0 + 1) begin
      errors++; $display("FAIL short_pulses: done=%0d err=%0d want 0/1", n_done0 - d0, n_err0 - e0);
    end
  endtask

  task automatic test_timeout();
    int lat, n;
    logic prev;
    req1_lba = 32'h400; req1_rd = 1'b1;
    wait_grant(lat);
    rr_last = 1;
    n = -1; prev = 1'bx;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk_sys);
      if (req1_err) begin n = i; break; end
      prev = sd_rd;
    end
    checks++;
    if (n != 1001) begin errors++; $display("FAIL timeout_cycle: got %0d want 1001", n); end
    checks++;
    if (sd_rd !== 1'b0 || prev !== 1'b1) begin
      errors++; $display("FAIL timeout_rd_drop: rd=%b before=%b want 0/1", sd_rd, prev);
    end
    req1_rd = 1'b0;
    cyc(3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, who, tot;
    bit ok;
    req0_lba = 32'h500; req0_rd = 1'b1;
    wait_grant(lat);
    spi_read(50, 0, 1'b0);
    tot = n_done0 + n_err0 + n_done1 + n_err1;
    reset = 1'b1; req0_rd = 1'b0;
    cyc(2);
    checks++;
    if ({sd_rd, sd_wr, busy} !== 3'b0 || sd_lba !== 32'h0 || sd_din !== 8'h0 || buf_dout !== 8'h0) begin
      errors++; $display("FAIL midreset_outputs: rd=%b wr=%b busy=%b lba=%h din=%h bdout=%h want 0",
        sd_rd, sd_wr, busy, sd_lba, sd_din, buf_dout);
    end
    reset = 1'b0;
    rr_last = 1;
    cyc(10);
    checks++;
    if ({sd_rd, sd_wr, busy} !== 3'b0) begin
      errors++; $display("FAIL midreset_stale_ack: rd=%b wr=%b busy=%b want 0", sd_rd, sd_wr, busy);
    end
    sd_ack = 1'b0;
    cyc(10);
    checks++;
    if (busy !== 1'b0 || n_done0 + n_err0 + n_done1 + n_err1 != tot) begin
      errors++; $display("FAIL midreset_no_pulse: busy=%b pulses=%0d want 0/0", busy, n_done0 + n_err0 + n_done1 + n_err1 - tot);
    end
    req1_lba = 32'h600; req1_rd = 1'b1;
    wait_grant(lat);
    checks++;
    if (lat != 1 || sd_lba !== 32'h600) begin
      errors++; $display("FAIL recover_grant: lat=%0d lba=%h want 1/600", lat, sd_lba);
    end
    spi_read(512, 7, 1'b1);
    sd_ack = 1'b0;
    wait_finish(who, ok);
    checks++;
    if (who != 1 || ok !== 1'b1) begin
      errors++; $display("FAIL recover_done: who=%0d done=%b want 1/1", who, ok);
    end
    check_readback("recover_buf");
  endtask

  initial begin
    reset = 1'b1;
    req0_lba = '0; req1_lba = '0;
    req0_rd = 0; req0_wr = 0; req1_rd = 0; req1_wr = 0;
    buf_addr = '0; buf_din = '0; buf_we = 0;
    sd_ack = 0; sd_dout = '0; sd_dout_strobe = 0; sd_din_strobe = 0;
    test_reset();
    test_read();
    test_write();
    test_contention("contend_a");
    test_short();
    test_contention("contend_b");
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
